rob_writeback_arb: RTL

//  Completion/writeback arbiter: the driver side of the ROB update interface (dup1/dup2 requests).

---
 rtl/rob_writeback_arb.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/rob_writeback_arb.sv
// Completion/writeback arbiter: one holding register per functional unit, up to two
// round-robin grants per cycle, registered ROB-update / CDB broadcast on two lanes.
module rob_writeback_arb #(
  parameter int NUM_FU  = 4,
  parameter int ROB_IDX = 5,
  parameter int PRF_IDX = 6,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      branch_miss,
  input  logic [NUM_FU-1:0]         fu_valid,
  output logic [NUM_FU-1:0]         fu_ready,
  input  logic [NUM_FU*ROB_IDX-1:0] fu_rob_idx,
  input  logic [NUM_FU*PRF_IDX-1:0] fu_pdest,
  input  logic [NUM_FU*DATA_W-1:0]  fu_value,
  input  logic [NUM_FU-1:0]         fu_bt,
  input  logic [NUM_FU*DATA_W-1:0]  fu_ba,
  output logic                      dup1_req,
  output logic                      dup2_req,
  output logic [ROB_IDX-1:0]        rob_idx_out1,
  output logic [ROB_IDX-1:0]        rob_idx_out2,
  output logic                      bt_ex_out1,
  output logic                      bt_ex_out2,
  output logic [DATA_W-1:0]         ba_ex_out1,
  output logic [DATA_W-1:0]         ba_ex_out2,
  output logic [PRF_IDX-1:0]        cdb_pdest1,
  output logic [PRF_IDX-1:0]        cdb_pdest2,
  output logic [DATA_W-1:0]         cdb_value1,
  output logic [DATA_W-1:0]         cdb_value2
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTR_W-1:0] LAST_FU = PTR_W'(NUM_FU - 1);

  logic [NUM_FU-1:0]  hold_v_q;
  logic [ROB_IDX-1:0] hold_rob_q   [NUM_FU];
  logic [PRF_IDX-1:0] hold_pdest_q [NUM_FU];
  logic [DATA_W-1:0]  hold_value_q [NUM_FU];
  logic               hold_bt_q    [NUM_FU];
  logic [DATA_W-1:0]  hold_ba_q    [NUM_FU];

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   cand_s;
  logic [NUM_FU-1:0]  grant_s;
  logic               g1_v_s, g2_v_s;
  logic [PTR_W-1:0]   g1_idx_s, g2_idx_s;

  // A hold can accept a new result while empty or while it is being drained this cycle.
  assign fu_ready = {NUM_FU{~branch_miss}} & (~hold_v_q | grant_s);

  // Round-robin scan starting at rr_ptr_q: first valid hold takes lane 1, second takes lane 2.
  always_comb begin
    grant_s  = '0;
    g1_v_s   = 1'b0;
    g2_v_s   = 1'b0;
    g1_idx_s = '0;
    g2_idx_s = '0;
    cand_s   = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      cand_s = PTR_W'((int'(rr_ptr_q) + k) % NUM_FU);
      if (!branch_miss && hold_v_q[cand_s] && !g1_v_s) begin
        g1_v_s          = 1'b1;
        g1_idx_s        = cand_s;
        grant_s[cand_s] = 1'b1;
      end else if (!branch_miss && hold_v_q[cand_s] && !g2_v_s) begin
        g2_v_s          = 1'b1;
        g2_idx_s        = cand_s;
        grant_s[cand_s] = 1'b1;
      end else begin
      end
    end
  end

  // Pointer moves past the last index granted; it stays put on idle cycles.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (g2_v_s) begin
      rr_ptr_d = (g2_idx_s == LAST_FU) ? '0 : g2_idx_s + PTR_W'(1);
    end else if (g1_v_s) begin
      rr_ptr_d = (g1_idx_s == LAST_FU) ? '0 : g1_idx_s + PTR_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Hold registers: squash on mispredict, refill on handshake, otherwise drain on grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_v_q <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        hold_rob_q[i]   <= '0;
        hold_pdest_q[i] <= '0;
        hold_value_q[i] <= '0;
        hold_bt_q[i]    <= 1'b0;
        hold_ba_q[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (branch_miss) begin
          hold_v_q[i] <= 1'b0;
        end else if (fu_valid[i] && fu_ready[i]) begin
          hold_v_q[i]     <= 1'b1;
          hold_rob_q[i]   <= fu_rob_idx[i*ROB_IDX +: ROB_IDX];
          hold_pdest_q[i] <= fu_pdest[i*PRF_IDX +: PRF_IDX];
          hold_value_q[i] <= fu_value[i*DATA_W +: DATA_W];
          hold_bt_q[i]    <= fu_bt[i];
          hold_ba_q[i]    <= fu_ba[i*DATA_W +: DATA_W];
        end else if (grant_s[i]) begin
          hold_v_q[i] <= 1'b0;
        end else begin
          hold_v_q[i] <= hold_v_q[i];
        end
      end
    end
  end

  // Arbitration pointer and the two registered writeback lanes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      dup1_req     <= 1'b0;
      dup2_req     <= 1'b0;
      rob_idx_out1 <= '0;
      rob_idx_out2 <= '0;
      bt_ex_out1   <= 1'b0;
      bt_ex_out2   <= 1'b0;
      ba_ex_out1   <= '0;
      ba_ex_out2   <= '0;
      cdb_pdest1   <= '0;
      cdb_pdest2   <= '0;
      cdb_value1   <= '0;
      cdb_value2   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      dup1_req     <= g1_v_s;
      dup2_req     <= g2_v_s;
      rob_idx_out1 <= hold_rob_q[g1_idx_s];
      rob_idx_out2 <= hold_rob_q[g2_idx_s];
      bt_ex_out1   <= hold_bt_q[g1_idx_s];
      bt_ex_out2   <= hold_bt_q[g2_idx_s];
      ba_ex_out1   <= hold_ba_q[g1_idx_s];
      ba_ex_out2   <= hold_ba_q[g2_idx_s];
      cdb_pdest1   <= hold_pdest_q[g1_idx_s];
      cdb_pdest2   <= hold_pdest_q[g2_idx_s];
      cdb_value1   <= hold_value_q[g1_idx_s];
      cdb_value2   <= hold_value_q[g2_idx_s];
    end
  end

endmodule
